// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: sole owner of the GPR-file write port. Clears x1..x(GPRS-1)
// after reset, then round-robins ALU/LSU writebacks into one registered write per cycle.
module rf_write_arbiter #(
    parameter int unsigned N    = 32,
    parameter int unsigned GPRS = 32,
    parameter int unsigned AW   = $clog2(GPRS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [N-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [N-1:0]  req1_data,
    output logic          req1_ready,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [N-1:0]  rf_wdata,
    output logic          init_done
);

    localparam int unsigned CW = $clog2(GPRS);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rr_q, rr_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic          grant0, grant1;

    if (GPRS < 4 || (GPRS & (GPRS - 1)) != 0) begin : g_bad_gprs
        $error("rf_write_arbiter: GPRS must be a power of two and >= 4");
    end

    // State, sweep counter, rr pointer and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= CW'(1);
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state: clear sweep in INIT, round-robin grant in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        grant0  = 1'b0;
        grant1  = 1'b0;

        case (state_q)
            S_INIT: begin
                we_d    = 1'b1;
                waddr_d = AW'(cnt_q);
                wdata_d = '0;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(GPRS - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (req0_valid && req1_valid) begin
                    grant0 = ~rr_q;
                    grant1 = rr_q;
                end else begin
                    grant0 = req0_valid;
                    grant1 = req1_valid;
                end

                // x0 writes are accepted and rotate the pointer but never reach the file.
                if (grant0) begin
                    rr_d = 1'b1;
                    if (req0_addr != '0) begin
                        we_d    = 1'b1;
                        waddr_d = req0_addr;
                        wdata_d = req0_data;
                    end
                end else if (grant1) begin
                    rr_d = 1'b0;
                    if (req1_addr != '0) begin
                        we_d    = 1'b1;
                        waddr_d = req1_addr;
                        wdata_d = req1_data;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rf_we      = we_q;
    assign rf_waddr   = waddr_q;
    assign rf_wdata   = wdata_q;
    assign init_done  = (state_q == S_RUN);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a randomized run checked
// against a grant/register-file model kept here.
module tb_rf_write_arbiter;

    localparam int N    = 32;
    localparam int GPRS = 32;
    localparam int CW   = 5;
    localparam int AW   = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr  = '0;
    logic [N-1:0]  req0_data  = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr  = '0;
    logic [N-1:0]  req1_data  = '0;
    logic          req1_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [N-1:0]  rf_wdata;
    logic          init_done;

    int total = 0;
    int bad   = 0;

    // Register file driven by the DUT (writes on negedge); power-up junk pattern.
    logic [N-1:0] rf_mem [GPRS] = '{default: 32'hA5A5_0000};
    // Contents the register file should hold, built from the model.
    logic [N-1:0] exp_mem [GPRS];
    // Model: index of the requester preferred when both are valid.
    int rr_m = 0;

    rf_write_arbiter #(.N(N), .GPRS(GPRS), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .init_done  (init_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_we && rf_waddr < AW'(GPRS)) rf_mem[rf_waddr[CW-1:0]] = rf_wdata;
    end

    function automatic int model_grant(input logic v0, input logic v1);
        if (v0 && v1) return rr_m;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
        total++; if (rf_waddr !== '0) begin bad++; $display("FAIL reset_waddr got=%0h exp=0", rf_waddr); end
        total++; if (rf_wdata !== '0) begin bad++; $display("FAIL reset_wdata got=%0h exp=0", rf_wdata); end
        total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        total++; if (init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b exp=0", init_done); end
        tick();
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_hold_we got=%b exp=0", rf_we); end
    endtask

    task automatic test_sweep();
        rst = 1'b0;
        for (int c = 1; c <= 31; c++) begin
            tick();
            total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL sweep_we c=%0d got=%b exp=1", c, rf_we); end
            total++; if (rf_waddr !== AW'(c)) begin bad++; $display("FAIL sweep_waddr c=%0d got=%0d exp=%0d", c, rf_waddr, c); end
            total++; if (rf_wdata !== '0) begin bad++; $display("FAIL sweep_wdata c=%0d got=%0h exp=0", c, rf_wdata); end
            total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL sweep_ready c=%0d got=%b%b exp=00", c, req0_ready, req1_ready); end
            if (c < 31) begin
                total++; if (init_done !== 1'b0) begin bad++; $display("FAIL sweep_init_done c=%0d got=%b exp=0", c, init_done); end
            end
        end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL sweep_end_we got=%b exp=0", rf_we); end
        total++; if (init_done !== 1'b1) begin bad++; $display("FAIL sweep_end_init_done got=%b exp=1", init_done); end
        @(negedge clk);
        #1;
        total++; if (rf_mem[0] !== 32'hA5A5_0000) begin bad++; $display("FAIL sweep_x0_untouched got=%0h exp=a5a50000", rf_mem[0]); end
        for (int i = 1; i < GPRS; i++) begin
            total++; if (rf_mem[i] !== '0) begin bad++; $display("FAIL sweep_cleared x%0d got=%0h exp=0", i, rf_mem[i]); end
        end
        exp_mem[0] = 32'hA5A5_0000;
        for (int i = 1; i < GPRS; i++) exp_mem[i] = '0;
        rr_m = 0;
        tick();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = AW'(5); req0_data = 32'hDEAD_BEEF;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL single0_ready got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(5) || rf_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single0_write got=%b/%0d/%0h exp=1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL single0_idle_we got=%b exp=0", rf_we); end
        total++; if (rf_waddr !== AW'(5) || rf_wdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL single0_hold got=%0d/%0h exp=5/deadbeef", rf_waddr, rf_wdata); end
        rr_m = 1; exp_mem[5] = 32'hDEAD_BEEF;

        req1_valid = 1'b1; req1_addr = AW'(6); req1_data = 32'h6666_6666;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL single1_ready got=%b%b exp=01", req0_ready, req1_ready); end
        tick();
        req1_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(6) || rf_wdata !== 32'h6666_6666) begin
            bad++; $display("FAIL single1_write got=%b/%0d/%0h exp=1/6/66666666", rf_we, rf_waddr, rf_wdata); end
        rr_m = 0; exp_mem[6] = 32'h6666_6666;
    endtask

    task automatic test_alternate();
        int exp_g [5] = '{0, 1, 0, 1, 0};
        req0_valid = 1'b1; req0_addr = AW'(3); req0_data = 32'h11;
        req1_valid = 1'b1; req1_addr = AW'(4); req1_data = 32'h22;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req1_valid = 1'b0;
            #1;
            total++; if (req0_ready !== (exp_g[k] == 0) || req1_ready !== (exp_g[k] == 1)) begin
                bad++; $display("FAIL alt_ready k=%0d got=%b%b exp_grant=%0d", k, req0_ready, req1_ready, exp_g[k]); end
            tick();
            total++; if (rf_we !== 1'b1 || rf_waddr !== ((exp_g[k] == 0) ? AW'(3) : AW'(4))
                         || rf_wdata !== ((exp_g[k] == 0) ? 32'h11 : 32'h22)) begin
                bad++; $display("FAIL alt_write k=%0d got=%b/%0d/%0h exp_grant=%0d", k, rf_we, rf_waddr, rf_wdata, exp_g[k]); end
            rr_m = 1 - exp_g[k];
        end
        req0_valid = 1'b0;
        exp_mem[3] = 32'h11; exp_mem[4] = 32'h22;
    endtask

    task automatic test_same_dest();
        req0_valid = 1'b1; req0_addr = AW'(7); req0_data = 32'hA;
        req1_valid = 1'b1; req1_addr = AW'(7); req1_data = 32'hB;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL same_first_ready got=%b%b exp=01", req0_ready, req1_ready); end
        tick();
        req1_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(7) || rf_wdata !== 32'hB) begin
            bad++; $display("FAIL same_first_write got=%b/%0d/%0h exp=1/7/b", rf_we, rf_waddr, rf_wdata); end
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL same_second_ready got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(7) || rf_wdata !== 32'hA) begin
            bad++; $display("FAIL same_second_write got=%b/%0d/%0h exp=1/7/a", rf_we, rf_waddr, rf_wdata); end
        @(negedge clk);
        #1;
        total++; if (rf_mem[7] !== 32'hA) begin bad++; $display("FAIL same_x7_read got=%0h exp=a", rf_mem[7]); end
        rr_m = 1; exp_mem[7] = 32'hA;
        tick();
    endtask

    task automatic test_x0();
        req1_valid = 1'b1; req1_addr = '0; req1_data = 32'hFFFF_FFFF;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL x0_ready got=%b%b exp=01", req0_ready, req1_ready); end
        tick();
        req1_valid = 1'b0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_no_write got=%b exp=0", rf_we); end
        rr_m = 0;
        req0_valid = 1'b1; req0_addr = AW'(9);  req0_data = 32'h99;
        req1_valid = 1'b1; req1_addr = AW'(10); req1_data = 32'h1010;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL x0_rr_moved got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        total++; if (rf_waddr !== AW'(9) || rf_wdata !== 32'h99) begin bad++; $display("FAIL x0_after0 got=%0d/%0h exp=9/99", rf_waddr, rf_wdata); end
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL x0_after1_ready got=%b%b exp=01", req0_ready, req1_ready); end
        tick();
        req1_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(10) || rf_wdata !== 32'h1010) begin
            bad++; $display("FAIL x0_after1 got=%b/%0d/%0h exp=1/10/1010", rf_we, rf_waddr, rf_wdata); end
        rr_m = 0; exp_mem[9] = 32'h99; exp_mem[10] = 32'h1010;
    endtask

    task automatic test_high_addr();
        req0_valid = 1'b1; req0_addr = AW'(6'h25); req0_data = 32'h1234_5678;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL high_ready got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(6'h25) || rf_wdata !== 32'h1234_5678) begin
            bad++; $display("FAIL high_passthru got=%b/%0h/%0h exp=1/25/12345678", rf_we, rf_waddr, rf_wdata); end
        rr_m = 1;
    endtask

    task automatic test_random();
        logic          p0 = 1'b0, p1 = 1'b0, exp_we, last_known = 1'b0;
        logic [AW-1:0] a0 = '0, a1 = '0, wa = '0, last_a = '0;
        logic [N-1:0]  d0 = '0, d1 = '0, wd = '0, last_d = '0;
        int            g;
        for (int cyc = 0; cyc < 1000 && (cyc < 400 || p0 || p1); cyc++) begin
            if (!p0 && cyc < 400 && $urandom_range(0, 2) != 0) begin
                p0 = 1'b1; d0 = $urandom;
                a0 = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, GPRS - 1));
            end
            if (!p1 && cyc < 400 && $urandom_range(0, 2) != 0) begin
                p1 = 1'b1; d1 = $urandom;
                a1 = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, GPRS - 1));
            end
            req0_valid = p0; req0_addr = a0; req0_data = d0;
            req1_valid = p1; req1_addr = a1; req1_data = d1;
            #1;
            g = model_grant(p0, p1);
            total++; if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b%b exp_grant=%0d", cyc, req0_ready, req1_ready, g); end
            tick();
            exp_we = 1'b0;
            if (g == 0) begin wa = a0; wd = d0; p0 = 1'b0; end
            if (g == 1) begin wa = a1; wd = d1; p1 = 1'b0; end
            if (g >= 0) begin rr_m = 1 - g; exp_we = (wa != '0); end
            total++; if (rf_we !== exp_we) begin bad++; $display("FAIL rand_we cyc=%0d got=%b exp=%b", cyc, rf_we, exp_we); end
            if (exp_we) begin
                total++; if (rf_waddr !== wa || rf_wdata !== wd) begin
                    bad++; $display("FAIL rand_write cyc=%0d got=%0d/%0h exp=%0d/%0h", cyc, rf_waddr, rf_wdata, wa, wd); end
                exp_mem[wa[CW-1:0]] = wd;
                last_known = 1'b1; last_a = wa; last_d = wd;
            end else if (g < 0 && last_known) begin
                total++; if (rf_waddr !== last_a || rf_wdata !== last_d) begin
                    bad++; $display("FAIL rand_hold cyc=%0d got=%0d/%0h exp=%0d/%0h", cyc, rf_waddr, rf_wdata, last_a, last_d); end
            end else if (g >= 0) begin
                last_known = 1'b0;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++; if (p0 || p1) begin bad++; $display("FAIL rand_drain got=%b%b exp=00", p0, p1); end
        @(negedge clk);
        #1;
        for (int i = 0; i < GPRS; i++) begin
            total++; if (rf_mem[i] !== exp_mem[i]) begin bad++; $display("FAIL rand_rf x%0d got=%0h exp=%0h", i, rf_mem[i], exp_mem[i]); end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_addr = AW'(12); req0_data = 32'h00C0_FFEE;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL midrun_accept got=%b exp=1", req0_ready); end
        rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0 || req0_ready !== 1'b0 || init_done !== 1'b0) begin
            bad++; $display("FAIL midrun_reset got=we%b rdy%b done%b exp=000", rf_we, req0_ready, init_done); end
        req0_valid = 1'b0;
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL midrun_lost got=%b exp=0", rf_we); end
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(c)) begin
                bad++; $display("FAIL midsweep_pre c=%0d got=%b/%0d exp=1/%0d", c, rf_we, rf_waddr, c); end
        end
        rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0 || init_done !== 1'b0) begin
            bad++; $display("FAIL midsweep_reset got=we%b done%b exp=00", rf_we, init_done); end
        tick();
        rst = 1'b0;
        rr_m = 0;
        req0_valid = 1'b1; req0_addr = AW'(13); req0_data = 32'h13;
        req1_valid = 1'b1; req1_addr = AW'(14); req1_data = 32'h14;
        for (int c = 1; c <= 31; c++) begin
            tick();
            total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(c) || rf_wdata !== '0) begin
                bad++; $display("FAIL resweep c=%0d got=%b/%0d/%0h exp=1/%0d/0", c, rf_we, rf_waddr, rf_wdata, c); end
            if (c < 31) begin
                total++; if ({req0_ready, req1_ready, init_done} !== 3'b000) begin
                    bad++; $display("FAIL resweep_hold c=%0d got=%b%b%b exp=000", c, req0_ready, req1_ready, init_done); end
            end
        end
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL resweep_first_grant got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(13) || rf_wdata !== 32'h13 || init_done !== 1'b1) begin
            bad++; $display("FAIL resweep_w0 got=%b/%0d/%0h done%b exp=1/13/13 done1", rf_we, rf_waddr, rf_wdata, init_done); end
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL resweep_second_grant got=%b%b exp=01", req0_ready, req1_ready); end
        tick();
        req1_valid = 1'b0;
        total++; if (rf_we !== 1'b1 || rf_waddr !== AW'(14) || rf_wdata !== 32'h14) begin
            bad++; $display("FAIL resweep_w1 got=%b/%0d/%0h exp=1/14/14", rf_we, rf_waddr, rf_wdata); end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL resweep_idle got=%b exp=0", rf_we); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_single();
        test_alternate();
        test_same_dest();
        test_x0();
        test_high_addr();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
